// File: rtl/mac_tile_driver.sv
// West/north-side transmitter for a mac_tile: turns load/execute commands and activation beats into spaced inst_w pulses.
// Optional build macro MAC_TILE_DRIVER_STATS_EN adds saturating stat_loads / stat_execs pulse counters.
module mac_tile_driver #(
    parameter int a_bw    = 2,
    parameter int w_bw    = 4,
    parameter int psum_bw = 16,
    parameter int GAP_CYC = 1,
    parameter int LEN_BW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic               cmd_mode,
    input  logic [w_bw-1:0]    cmd_w0,
    input  logic [w_bw-1:0]    cmd_w1,
    input  logic [LEN_BW-1:0]  cmd_len,
    input  logic               act_valid,
    output logic               act_ready,
    input  logic [2*a_bw-1:0]  act_data,
    input  logic [psum_bw-1:0] act_psum0,
    input  logic [psum_bw-1:0] act_psum1,
    output logic               ctrl,
    output logic [w_bw-1:0]    out_w_0,
    output logic [w_bw-1:0]    out_w_1,
    output logic [a_bw-1:0]    out_x_0,
    output logic [a_bw-1:0]    out_x_1,
    output logic [1:0]         inst_w,
    output logic [psum_bw-1:0] out_psum_c_0,
    output logic [psum_bw-1:0] out_psum_c_1,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef MAC_TILE_DRIVER_STATS_EN
    ,
    output logic [15:0]        stat_loads,
    output logic [15:0]        stat_execs
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        EXEC = 3'd2,
        GAP  = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam logic       GAP_ZERO = (GAP_CYC == 0);
    localparam logic [2:0] GAP_LOAD = 3'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    state_t              state_reg, state_next;
    logic                issue_reg, issue_next;
    logic [2:0]          gap_cnt_reg, gap_cnt_next;
    logic [LEN_BW-1:0]   remaining_reg, remaining_next;
    logic                weights_valid_reg, weights_valid_next;
    logic                loaded_mode_reg, loaded_mode_next;
    logic                ctrl_reg, ctrl_next;
    logic [1:0]          inst_w_reg, inst_w_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic                cmd_ready_reg, cmd_ready_next;
    logic                act_ready_reg, act_ready_next;
    logic                cmd_fire, act_fire;
    logic                load_fire, exec_fire;

    // Per-lane inputs; lane 1 weight broadcasts lane 0 in 4-bit mode.
    logic [1:0][w_bw-1:0]    w_in;
    logic [1:0][a_bw-1:0]    x_in;
    logic [1:0][psum_bw-1:0] psum_in;

    assign w_in[0]    = cmd_w0;
    assign w_in[1]    = cmd_mode ? cmd_w0 : cmd_w1;
    assign x_in       = act_data;
    assign psum_in[0] = act_psum0;
    assign psum_in[1] = act_psum1;

    assign cmd_fire = cmd_valid && cmd_ready_reg;
    assign act_fire = act_valid && act_ready_reg;

    always_comb begin
        state_next         = state_reg;
        issue_next         = 1'b0;
        gap_cnt_next       = gap_cnt_reg;
        remaining_next     = remaining_reg;
        weights_valid_next = weights_valid_reg;
        loaded_mode_next   = loaded_mode_reg;
        ctrl_next          = ctrl_reg;
        inst_w_next        = 2'b00;
        done_next          = 1'b0;
        err_next           = 1'b0;
        load_fire          = 1'b0;
        exec_fire          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    ctrl_next = cmd_mode;
                    if (!cmd_op) begin
                        state_next         = LOAD;
                        inst_w_next        = 2'b01;
                        load_fire          = 1'b1;
                        weights_valid_next = 1'b1;
                        loaded_mode_next   = cmd_mode;
                    end else if (!weights_valid_reg || (cmd_mode != loaded_mode_reg)) begin
                        err_next = 1'b1;
                    end else if (cmd_len == '0) begin
                        state_next = FIN;
                        done_next  = 1'b1;
                    end else begin
                        state_next     = EXEC;
                        remaining_next = cmd_len;
                    end
                end
            end

            LOAD: begin
                if (!GAP_ZERO) begin
                    state_next   = GAP;
                    gap_cnt_next = GAP_LOAD;
                end else begin
                    state_next = FIN;
                    done_next  = 1'b1;
                end
            end

            EXEC: begin
                // issue_reg marks the cycle the execute pulse is on the outputs.
                if (issue_reg && !GAP_ZERO) begin
                    state_next   = GAP;
                    gap_cnt_next = GAP_LOAD;
                end else if (issue_reg && (remaining_reg == '0)) begin
                    state_next = FIN;
                    done_next  = 1'b1;
                end else if (act_fire) begin
                    issue_next     = 1'b1;
                    inst_w_next    = 2'b10;
                    exec_fire      = 1'b1;
                    remaining_next = remaining_reg - LEN_BW'(1);
                end
            end

            GAP: begin
                if (gap_cnt_reg == 3'd0) begin
                    if (remaining_reg != '0) begin
                        state_next = EXEC;
                    end else begin
                        state_next = FIN;
                        done_next  = 1'b1;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg - 3'd1;
                end
            end

            FIN: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next      = (state_next != IDLE);
        cmd_ready_next = (state_next == IDLE);
        // With no gap, the next beat may be taken during the pulse cycle itself.
        act_ready_next = (state_next == EXEC) &&
                         (!issue_next || (GAP_ZERO && (remaining_next != '0)));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg         <= IDLE;
            issue_reg         <= 1'b0;
            gap_cnt_reg       <= 3'd0;
            remaining_reg     <= '0;
            weights_valid_reg <= 1'b0;
            loaded_mode_reg   <= 1'b0;
            ctrl_reg          <= 1'b0;
            inst_w_reg        <= 2'b00;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            err_reg           <= 1'b0;
            cmd_ready_reg     <= 1'b1;
            act_ready_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            issue_reg         <= issue_next;
            gap_cnt_reg       <= gap_cnt_next;
            remaining_reg     <= remaining_next;
            weights_valid_reg <= weights_valid_next;
            loaded_mode_reg   <= loaded_mode_next;
            ctrl_reg          <= ctrl_next;
            inst_w_reg        <= inst_w_next;
            busy_reg          <= busy_next;
            done_reg          <= done_next;
            err_reg           <= err_next;
            cmd_ready_reg     <= cmd_ready_next;
            act_ready_reg     <= act_ready_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [w_bw-1:0]    w_reg;
            logic [a_bw-1:0]    x_reg;
            logic [psum_bw-1:0] psum_reg;

            // Data registers hold between pulses; psums are passed through untouched.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    w_reg    <= '0;
                    x_reg    <= '0;
                    psum_reg <= '0;
                end else begin
                    if (load_fire) begin
                        w_reg <= w_in[gi];
                    end
                    if (exec_fire) begin
                        x_reg    <= x_in[gi];
                        psum_reg <= psum_in[gi];
                    end
                end
            end
        end
    endgenerate

    assign out_w_0      = g_lane[0].w_reg;
    assign out_w_1      = g_lane[1].w_reg;
    assign out_x_0      = g_lane[0].x_reg;
    assign out_x_1      = g_lane[1].x_reg;
    assign out_psum_c_0 = g_lane[0].psum_reg;
    assign out_psum_c_1 = g_lane[1].psum_reg;

    assign ctrl      = ctrl_reg;
    assign inst_w    = inst_w_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign cmd_ready = cmd_ready_reg;
    assign act_ready = act_ready_reg;

`ifdef MAC_TILE_DRIVER_STATS_EN
    logic [15:0] stat_loads_reg;
    logic [15:0] stat_execs_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_loads_reg <= 16'd0;
            stat_execs_reg <= 16'd0;
        end else begin
            if (load_fire && (stat_loads_reg != 16'hFFFF)) begin
                stat_loads_reg <= stat_loads_reg + 16'd1;
            end
            if (exec_fire && (stat_execs_reg != 16'hFFFF)) begin
                stat_execs_reg <= stat_execs_reg + 16'd1;
            end
        end
    end

    assign stat_loads = stat_loads_reg;
    assign stat_execs = stat_execs_reg;
`endif

endmodule
